// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Sequences CPU-side requests onto a 16-bit word memory: single-word writes,
// incrementing read bursts of 1..16 words, and read data returned over a
// valid/ready response channel. Sole driver of load/out_en, so they never overlap.
module mem_access_ctrl #(
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [3:0]  req_len,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_last,
    output logic        busy,
    output logic [15:0] address,
    output logic        load,
    output logic        out_en,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    localparam int               LAT_W    = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LAT - 1);

    state_t           state, state_next;
    logic [LAT_W-1:0] lat_cnt, lat_cnt_d;
    logic [3:0]       beats_left, beats_left_d;
    logic [15:0]      address_d, mem_wdata_d, rsp_data_d;
    logic             load_d, out_en_d, rsp_valid_d, rsp_last_d;
    logic             accept, lat_done;

    // req_ready is the only output decoded from state rather than registered;
    // it is held low while reset is asserted.
    assign req_ready = (state == IDLE) && !reset;
    assign accept    = req_valid && req_ready;
    assign lat_done  = (lat_cnt == LAT_LAST);

    // State register plus every registered output and datapath register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            beats_left <= 4'd0;
            address    <= 16'h0000;
            mem_wdata  <= 16'h0000;
            rsp_data   <= 16'h0000;
            load       <= 1'b0;
            out_en     <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_last   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            state      <= state_next;
            lat_cnt    <= lat_cnt_d;
            beats_left <= beats_left_d;
            address    <= address_d;
            mem_wdata  <= mem_wdata_d;
            rsp_data   <= rsp_data_d;
            load       <= load_d;
            out_en     <= out_en_d;
            rsp_valid  <= rsp_valid_d;
            rsp_last   <= rsp_last_d;
            busy       <= (state_next != IDLE);
        end
    end

    // Next-state decode.
    always_comb begin
        // NOTE: assigning a default first means no path leaves the signal
        // unassigned, so no latch is inferred.
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = req_write ? WRITE : READ;
            WRITE:   state_next = IDLE;
            READ:    if (lat_done) state_next = RESP;
            RESP:    if (rsp_ready) state_next = (beats_left == 4'd0) ? IDLE : READ;
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs; anything not touched holds.
    always_comb begin
        lat_cnt_d    = lat_cnt;
        beats_left_d = beats_left;
        address_d    = address;
        mem_wdata_d  = mem_wdata;
        rsp_data_d   = rsp_data;
        load_d       = load;
        out_en_d     = out_en;
        rsp_valid_d  = rsp_valid;
        rsp_last_d   = rsp_last;
        case (state)
            IDLE: begin
                load_d   = 1'b0;
                out_en_d = 1'b0;
                if (accept) begin
                    address_d = req_addr;
                    if (req_write) begin
                        mem_wdata_d = req_wdata;
                        load_d      = 1'b1;
                    end else begin
                        out_en_d     = 1'b1;
                        beats_left_d = req_len;
                        lat_cnt_d    = '0;
                    end
                end
            end
            WRITE: begin
                load_d = 1'b0;
            end
            READ: begin
                if (lat_done) begin
                    rsp_data_d  = mem_rdata;
                    rsp_valid_d = 1'b1;
                    rsp_last_d  = (beats_left == 4'd0);
                    out_en_d    = 1'b0;
                end else begin
                    lat_cnt_d = lat_cnt + 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (beats_left != 4'd0) begin
                        // Address wraps modulo 2^16 through plain 16-bit addition.
                        address_d    = address + 16'd1;
                        beats_left_d = beats_left - 4'd1;
                        lat_cnt_d    = '0;
                        out_en_d     = 1'b1;
                    end
                end
            end
            default: begin
                load_d   = 1'b0;
                out_en_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
// Two controller instances (READ_LAT=1 and READ_LAT=3) share one request bus;
// sel picks which one is live while the other is held in reset. Stimulus pushes
// expected writes, read addresses and response beats into queues; a monitor on
// the falling edge pops and compares whenever the live DUT shows activity.
module tb_mem_access_ctrl;

    typedef struct {
        logic [15:0] data;
        logic        last;
        int          cyc;
        bit          timed;
    } beat_t;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        int          cyc;
    } wr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, sel;
    logic        req_valid, req_write, rsp_ready;
    logic [15:0] req_addr, req_wdata;
    logic [3:0]  req_len;

    logic        rr1, rv1, rl1, b1, ld1, oe1;
    logic [15:0] rd1, a1, wd1, mrd1;
    logic        rr3, rv3, rl3, b3, ld3, oe3;
    logic [15:0] rd3, a3, wd3, mrd3;
    logic        reset1, reset3, v1, v3;

    assign reset1 = reset | sel;
    assign reset3 = reset | ~sel;
    assign v1     = req_valid & ~sel;
    assign v3     = req_valid & sel;

    mem_access_ctrl #(.READ_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset1), .req_valid(v1), .req_ready(rr1), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .rsp_valid(rv1),
        .rsp_ready(rsp_ready), .rsp_data(rd1), .rsp_last(rl1), .busy(b1), .address(a1),
        .load(ld1), .out_en(oe1), .mem_wdata(wd1), .mem_rdata(mrd1)
    );

    mem_access_ctrl #(.READ_LAT(3)) u_lat3 (
        .clk(clk), .reset(reset3), .req_valid(v3), .req_ready(rr3), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .rsp_valid(rv3),
        .rsp_ready(rsp_ready), .rsp_data(rd3), .rsp_last(rl3), .busy(b3), .address(a3),
        .load(ld3), .out_en(oe3), .mem_wdata(wd3), .mem_rdata(mrd3)
    );

    // Outputs of whichever instance is live.
    logic        m_req_ready, m_rsp_valid, m_rsp_last, m_busy, m_load, m_out_en;
    logic [15:0] m_rsp_data, m_address, m_mem_wdata;
    assign m_req_ready = sel ? rr3 : rr1;
    assign m_rsp_valid = sel ? rv3 : rv1;
    assign m_rsp_last  = sel ? rl3 : rl1;
    assign m_rsp_data  = sel ? rd3 : rd1;
    assign m_busy      = sel ? b3  : b1;
    assign m_load      = sel ? ld3 : ld1;
    assign m_out_en    = sel ? oe3 : oe1;
    assign m_address   = sel ? a3  : a1;
    assign m_mem_wdata = sel ? wd3 : wd1;

    // Power-up contents of the memory: distinct per address so misordered
    // or skipped addresses show up in the data.
    function automatic logic [15:0] init_val(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC35A;
    endfunction

    // Behavioural word memory with READ_LAT-cycle read delay per instance.
    logic [15:0] mem     [0:65535];
    bit          written [0:65535];
    logic [15:0] pipe1, pipe2;
    always @(posedge clk) begin
        if (ld1) begin mem[a1] <= wd1; written[a1] <= 1'b1; end
        if (ld3) begin mem[a3] <= wd3; written[a3] <= 1'b1; end
        pipe1 <= oe3 ? (written[a3] ? mem[a3] : init_val(a3)) : 16'hBAD0;
        pipe2 <= pipe1;
    end
    assign mrd1 = oe1 ? (written[a1] ? mem[a1] : init_val(a1)) : 16'hBAD0;
    assign mrd3 = pipe2;

    // Reference model: word-addressed memory image.
    logic [15:0] ref_mem [int];
    function automatic logic [15:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : init_val(a);
    endfunction

    beat_t       exp_beats [$];
    wr_t         exp_wr    [$];
    logic [15:0] exp_addr  [$];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int beats_seen = 0;
    int last_c0 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_msg(input string name, input string what);
        total++;
        bad++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int cur_lat();
        return sel ? 3 : 1;
    endfunction

    // Monitor: protocol invariants, write pulses, read addresses, response beats.
    logic        p_load = 1'b0, p_oe = 1'b0, p_valid = 1'b0, p_ready = 1'b0, p_last = 1'b0;
    logic [15:0] p_data = 16'h0, p_addr = 16'h0;
    int          rise_cyc = 0;

    initial begin : monitor
        beat_t       b;
        wr_t         w;
        logic [15:0] ea;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("load_oe_excl", 32'(m_load & m_out_en), 0);
                check("ready_vs_busy", 32'(m_req_ready), 32'(!m_busy));
                if (m_load) begin
                    check("load_width", 32'(p_load), 0);
                    if (exp_wr.size() == 0) fail_msg("wr_unexpected", "load with no write pending");
                    else begin
                        w = exp_wr.pop_front();
                        check("wr_addr", 32'(m_address), 32'(w.addr));
                        check("wr_data", 32'(m_mem_wdata), 32'(w.data));
                        check("wr_cycle", cyc, w.cyc);
                    end
                end
                if (m_out_en && !p_oe) begin
                    if (exp_addr.size() == 0) fail_msg("rd_unexpected", "out_en with no read pending");
                    else begin
                        ea = exp_addr.pop_front();
                        check("rd_addr", 32'(m_address), 32'(ea));
                    end
                end
                if (m_out_en && p_oe) check("rd_addr_hold", 32'(m_address), 32'(p_addr));
                if (p_valid && !p_ready) begin
                    check("stall_valid", 32'(m_rsp_valid), 1);
                    check("stall_data", 32'(m_rsp_data), 32'(p_data));
                    check("stall_last", 32'(m_rsp_last), 32'(p_last));
                end
                if (m_rsp_valid && !p_valid) rise_cyc = cyc;
                if (m_rsp_valid && rsp_ready) begin
                    if (exp_beats.size() == 0) fail_msg("beat_unexpected", "rsp beat with none pending");
                    else begin
                        b = exp_beats.pop_front();
                        check("rsp_data", 32'(m_rsp_data), 32'(b.data));
                        check("rsp_last", 32'(m_rsp_last), 32'(b.last));
                        if (b.timed) check("rsp_cycle", rise_cyc, b.cyc);
                    end
                    beats_seen++;
                end
            end
            p_load  = m_load;
            p_oe    = m_out_en;
            p_valid = m_rsp_valid;
            p_ready = rsp_ready;
            p_last  = m_rsp_last;
            p_data  = m_rsp_data;
            p_addr  = m_address;
        end
    end

    task automatic check_reset_outputs();
        check("rst_req_ready", 32'(m_req_ready), 0);
        check("rst_busy",      32'(m_busy), 0);
        check("rst_load",      32'(m_load), 0);
        check("rst_out_en",    32'(m_out_en), 0);
        check("rst_rsp_valid", 32'(m_rsp_valid), 0);
        check("rst_rsp_last",  32'(m_rsp_last), 0);
        check("rst_address",   32'(m_address), 0);
        check("rst_mem_wdata", 32'(m_mem_wdata), 0);
        check("rst_rsp_data",  32'(m_rsp_data), 0);
    endtask

    // Holds reset for n edges, checking outputs after each, then releases it.
    task automatic hold_reset(input int n);
        reset = 1'b1;
        exp_beats.delete();
        exp_wr.delete();
        exp_addr.delete();
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
            check_reset_outputs();
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rel_req_ready", 32'(m_req_ready), 1);
        check("rel_busy", 32'(m_busy), 0);
        tick();
    endtask

    // Presents one request until accepted and records what must come out of it.
    task automatic issue(input bit wr, input logic [15:0] a, input logic [15:0] d,
                         input logic [3:0] len, input bit timed);
        int          n;
        int          lat;
        logic [15:0] ai;
        beat_t       b;
        wr_t         w;
        n   = 0;
        lat = cur_lat();
        if (timed) rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        req_len   = len;
        while (!m_req_ready) begin
            tick();
            n++;
            if (n > 200) begin
                fail_msg("req_accept", "request never accepted");
                req_valid = 1'b0;
                return;
            end
        end
        last_c0 = cyc + 1;
        if (wr) begin
            ref_mem[int'(a)] = d;
            w.addr = a;
            w.data = d;
            w.cyc  = last_c0;
            exp_wr.push_back(w);
        end else begin
            for (int i = 0; i <= int'(len); i++) begin
                ai      = a + 16'(i);
                b.data  = ref_rd(ai);
                b.last  = (i == int'(len));
                b.cyc   = last_c0 + lat + i * (lat + 1);
                b.timed = timed;
                exp_beats.push_back(b);
                exp_addr.push_back(ai);
            end
        end
        tick();
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        req_len   = 4'($urandom);
    endtask

    // Runs until everything expected has been observed and the DUT is idle.
    // mode 0: rsp_ready high; 1: toggled every 2 cycles; 2: random.
    task automatic wait_idle(input int mode, input int bound);
        int k;
        k = 0;
        while (exp_beats.size() != 0 || exp_wr.size() != 0 || m_busy) begin
            case (mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = ((k / 2) % 2) == 1;
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
            tick();
            k++;
            if (k > bound) begin
                fail_msg("idle_wait", "transaction did not complete");
                exp_beats.delete();
                exp_wr.delete();
                exp_addr.delete();
                return;
            end
        end
        rsp_ready = 1'b1;
    endtask

    task automatic random_phase(input int n);
        for (int t = 0; t < n; t++) begin
            bit          wr;
            logic [15:0] a;
            wr = ($urandom_range(0, 2) == 0);
            a  = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                             : 16'h0100 + 16'($urandom_range(0, 15));
            issue(wr, a, 16'($urandom), 4'($urandom_range(0, 15)), 1'b0);
            wait_idle(2, 3000);
        end
    endtask

    initial begin : stimulus
        int c_first;
        int k;
        int target;
        reset     = 1'b1;
        sel       = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = 16'h0;
        req_wdata = 16'h0;
        req_len   = 4'h0;
        rsp_ready = 1'b1;

        // READ_LAT = 1 instance.
        hold_reset(2);

        issue(1'b1, 16'h0000, 16'h5A5A, 4'd0, 1'b1);
        c_first = last_c0;
        issue(1'b1, 16'h0010, 16'hA5A5, 4'd0, 1'b1);
        check("wr_b2b_spacing", last_c0 - c_first, 2);
        wait_idle(0, 50);

        issue(1'b0, 16'h0000, 16'h0, 4'd0, 1'b1);
        wait_idle(0, 50);
        issue(1'b0, 16'h0010, 16'h0, 4'd0, 1'b1);
        wait_idle(0, 50);

        issue(1'b0, 16'hFFFE, 16'h0, 4'd3, 1'b1);
        wait_idle(0, 100);
        issue(1'b0, 16'hFFFE, 16'h0, 4'd3, 1'b0);
        wait_idle(1, 200);

        random_phase(40);

        // READ_LAT = 3 instance.
        sel = 1'b1;
        hold_reset(2);

        issue(1'b0, 16'hFFFE, 16'h0, 4'd3, 1'b1);
        wait_idle(0, 100);
        issue(1'b0, 16'hFFFE, 16'h0, 4'd3, 1'b0);
        wait_idle(1, 300);

        random_phase(20);

        // Reset during the second beat of an 8-beat burst.
        issue(1'b0, 16'h0200, 16'h0, 4'd7, 1'b1);
        target = beats_seen + 1;
        k = 0;
        while (beats_seen < target && k <= 100) begin
            tick();
            k++;
        end
        if (beats_seen < target) fail_msg("first_beat", "first burst beat never seen");
        check("mid_burst_oe", 32'(m_out_en), 1);
        hold_reset(2);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            check("post_rst_rsp_valid", 32'(m_rsp_valid), 0);
            check("post_rst_out_en", 32'(m_out_en), 0);
            check("post_rst_load", 32'(m_load), 0);
            tick();
        end

        issue(1'b1, 16'h0300, 16'h1234, 4'd0, 1'b1);
        wait_idle(0, 50);
        issue(1'b0, 16'h0300, 16'h0, 4'd1, 1'b1);
        wait_idle(0, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
